pipelined_addsub: RTL and testbench
===================================

// Module: pipelined_addsub
// PURPOSE
//  Parametrised, pipelined two's-complement adder/subtractor; next generation of the lab 4-bit ripple adder.
//  Splits a WIDTH-bit add into CHUNK-bit ripple slices, one slice per pipeline stage, carry registered between stages.
//  Adds subtract mode, signed-overflow/zero flags and a valid/ready stream handshake.
//  Sits between switch/register sources and the LED/HEX display logic on the lab board.
// PARAMETERS
//  WIDTH   8   operand/result width in bits; WIDTH % CHUNK == 0 is required, otherwise elaboration fails
//  CHUNK   4   bits summed per pipeline stage; NSTAGE = WIDTH/CHUNK stages
// PORTS
//  clk        in   1      system clock, all state changes on rising edge
//  reset      in   1      synchronous, active-high reset
//  in_valid   in   1      operand beat present
//  in_ready   out  1      block accepts beat this cycle
//  sub        in   1      0: A+B, 1: A-B (A + ~B + 1)
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  out_valid  out  1      result beat present
//  out_ready  in   1      consumer accepts result this cycle
//  sum        out  WIDTH  result, modulo 2^WIDTH
//  cout       out  1      carry out of MSB (sub: 1 = no borrow, A>=B unsigned)
//  ovf        out  1      signed overflow: carry-in of MSB XOR carry-out of MSB
//  zero       out  1      sum == 0
// BEHAVIOUR
//  - Reset: all stage valid bits 0; out_valid=0, sum=0, cout=0, ovf=0, zero=0; in_ready=1 the cycle after reset.
//  - Each slice is a CHUNK-bit ripple of full adders: s = a^b^c, c' = ab|ac|bc.
//  - Stage k (0..NSTAGE-1) computes bits [k*CHUNK +: CHUNK] using the carry registered by stage k-1;
//    stage 0 carry-in = sub. B is inverted in stage 0 when sub=1.
//  - Unsummed upper operand bits and already-summed lower result bits travel with the beat (skew registers).
//  - Advance enable: adv = ~out_valid | out_ready. in_ready = adv (combinational).
//    adv=1: every stage shifts one step; stage 0 loads in_valid & operands.
//    adv=0: all stages hold (global stall); no beat lost or duplicated.
//  - Transfer in when in_valid & in_ready; transfer out when out_valid & out_ready.
//  - Latency: result of a beat accepted at edge N is on outputs (out_valid=1) after edge N+NSTAGE, no stalls.
//  - Throughput: one beat/cycle while out_ready=1; bubbles (in_valid=0) propagate as valid=0 stages.
//  - Outputs sum/cout/ovf/zero are registered, held stable while out_valid & ~out_ready.
//  - Data is don't-care when the matching valid bit is 0; regs still clear on reset.
//  - ovf uses the carry into bit WIDTH-1 and cout of the final stage; valid for both modes.
//  - Reset mid-operation: all in-flight beats discarded, out_valid=0 the next cycle; no partial result emitted.
//  - Simultaneous in/out transfer on the same edge with a full pipeline is legal, keeps it full.
//  - sub sampled only with its beat; changing sub between beats affects only the new beat.
// TESTING (WIDTH=8, CHUNK=4, NSTAGE=2)
//  1 add 0x0F+0x01, out_ready=1 -> 2 cycles later sum=0x10 cout=0 ovf=0 zero=0 (inter-stage carry).
//  2 add 0xFF+0x01 -> sum=0x00 cout=1 ovf=0 zero=1; add 0x7F+0x01 -> sum=0x80 cout=0 ovf=1.
//  3 sub 0x05-0x07 -> sum=0xFE cout=0 ovf=0; sub 0x80-0x01 -> sum=0x7F cout=1 ovf=1.
//  4 back-to-back 4 beats (1+1,2+2,3+3,4+4) with out_ready=1 -> out_valid 4 consecutive cycles, 2,4,6,8.
//  5 out_ready=0 for 5 cycles mid-stream -> in_ready=0, outputs held, all beats later emitted once in order.
//  6 reset asserted with 2 beats in flight -> out_valid=0 next cycle, no stale result after release.
//  Also: exhaustive 8-bit a,b x sub vs reference model, random out_ready/in_valid, scoreboard order check.

Source files
------------

// File: rtl/pipelined_addsub_if.sv
// Operand/result stream bundle for pipelined_addsub; carries no state or latency.
// The producer drives in_valid/sub/a/b and out_ready; the consumer drives in_ready and the result.
interface pipelined_addsub_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, sub, a, b, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, sub, a, b, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/pipelined_addsub.sv
// Pipelined add/sub: WIDTH-bit sum built from CHUNK-bit ripple slices, one slice per stage.
// Latency: beat accepted at edge N shows on the outputs after edge N+WIDTH/CHUNK.
// Backpressure: a global stall freezes every stage while out_valid & ~out_ready; in_ready = advance.
module pipelined_addsub #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input logic              clk,
  input logic              reset,
  pipelined_addsub_if.slave io
);
  localparam int NSTAGE = WIDTH / CHUNK;

  if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_width_check
    $error("pipelined_addsub: WIDTH must be a positive multiple of CHUNK");
  end

  // work[k]: bits below k*CHUNK are already summed, bits above are still operand A.
  logic [NSTAGE:0]  vld;
  logic [WIDTH-1:0] work [NSTAGE+1];
  logic [WIDTH-1:0] opb  [NSTAGE];
  logic             cin  [NSTAGE];
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;

  logic [WIDTH-1:0] work_nxt [NSTAGE];
  logic             cout_nxt [NSTAGE];
  logic             cmsb_nxt [NSTAGE];
  logic             rc;
  logic             ra;
  logic             rb;
  logic             adv;

  assign adv = ~vld[NSTAGE] | io.out_ready;

  always_comb begin
    rc = 1'b0;
    ra = 1'b0;
    rb = 1'b0;
    for (int k = 0; k < NSTAGE; k++) begin
      work_nxt[k] = work[k];
      cmsb_nxt[k] = 1'b0;
      rc          = cin[k];
      for (int i = 0; i < CHUNK; i++) begin
        ra = work[k][k*CHUNK+i];
        rb = opb[k][k*CHUNK+i];
        work_nxt[k][k*CHUNK+i] = ra ^ rb ^ rc;
        cmsb_nxt[k] = rc;
        rc = (ra & rb) | (ra & rc) | (rb & rc);
      end
      cout_nxt[k] = rc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      for (int k = 0; k <= NSTAGE; k++) begin
        work[k] <= '0;
      end
      for (int k = 0; k < NSTAGE; k++) begin
        opb[k] <= '0;
        cin[k] <= 1'b0;
      end
    end else if (adv) begin
      vld     <= {vld[NSTAGE-1:0], io.in_valid};
      work[0] <= io.a;
      opb[0]  <= io.sub ? ~io.b : io.b;
      cin[0]  <= io.sub;
      for (int k = 0; k < NSTAGE; k++) begin
        work[k+1] <= work_nxt[k];
      end
      for (int k = 1; k < NSTAGE; k++) begin
        opb[k] <= opb[k-1];
        cin[k] <= cout_nxt[k-1];
      end
      // Flags come from the last slice as the result drops into the output register.
      cout_q <= cout_nxt[NSTAGE-1];
      ovf_q  <= cout_nxt[NSTAGE-1] ^ cmsb_nxt[NSTAGE-1];
      zero_q <= (work_nxt[NSTAGE-1] == '0);
    end
  end

  assign io.in_ready  = adv;
  assign io.out_valid = vld[NSTAGE];
  assign io.sum       = work[NSTAGE];
  assign io.cout      = cout_q;
  assign io.ovf       = ovf_q;
  assign io.zero      = zero_q;
endmodule

// File: tb/tb_pipelined_addsub.sv
// Randomised and directed bench for pipelined_addsub (WIDTH=8, CHUNK=4) against an arithmetic model.
module tb_pipelined_addsub;
  localparam int WIDTH  = 8;
  localparam int CHUNK  = 4;
  localparam int NSTAGE = WIDTH / CHUNK;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
  } res_t;

  logic clk;
  logic reset;
  pipelined_addsub_if #(.WIDTH(WIDTH)) io ();

  pipelined_addsub #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  bit   lat_mode = 1'b0;
  bit   have_ovr = 1'b0;
  res_t ovr;
  res_t exp_q [$];
  int   acc_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sub);
    res_t r;
    int ua, ub, ur, sa, sb, sr;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    ur = sub ? ua - ub : ua + ub;
    sr = sub ? sa - sb : sa + sb;
    r.sum  = ur[WIDTH-1:0];
    r.cout = sub ? (ua >= ub) : (ur > 255);
    r.ovf  = (sr > 127) || (sr < -128);
    r.zero = (r.sum == '0);
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] pick();
    case ($urandom_range(0, 9))
      0:       return 8'h00;
      1:       return 8'h01;
      2:       return 8'h7F;
      3:       return 8'h80;
      4:       return 8'hFF;
      default: return 8'($urandom);
    endcase
  endfunction

  // One cycle: inputs are already set; decide transfers mid-cycle, then move to the next negedge.
  task automatic tick(output bit took);
    res_t e;
    int   t;
    #1;
    took = 1'b0;
    if (!reset) begin
      if (io.out_valid && io.out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 32'(io.out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          t = acc_q.pop_front();
          check("sum",  32'(io.sum),  32'(e.sum));
          check("cout", 32'(io.cout), 32'(e.cout));
          check("ovf",  32'(io.ovf),  32'(e.ovf));
          check("zero", 32'(io.zero), 32'(e.zero));
          if (lat_mode) check("latency", 32'(cyc - t), 32'(NSTAGE + 1));
        end
      end
      if (io.in_valid && io.in_ready) begin
        exp_q.push_back(have_ovr ? ovr : model(io.a, io.b, io.sub));
        acc_q.push_back(cyc);
        took = 1'b1;
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sub,
                      input bit use_ovr, input res_t exp);
    bit took;
    int n;
    io.in_valid = 1'b1;
    io.a        = a;
    io.b        = b;
    io.sub      = sub;
    have_ovr    = use_ovr;
    ovr         = exp;
    took        = 1'b0;
    n           = 0;
    while (!took && n < 50) begin
      tick(took);
      n++;
    end
    check("send_accept", 32'(took), 32'd1);
    io.in_valid = 1'b0;
    have_ovr    = 1'b0;
  endtask

  task automatic drain();
    bit took;
    int n;
    io.in_valid  = 1'b0;
    io.out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick(took);
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    repeat (3) tick(took);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   took;
    res_t held;
    reset        = 1'b1;
    io.in_valid  = 1'b0;
    io.sub       = 1'b0;
    io.a         = '0;
    io.b         = '0;
    io.out_ready = 1'b1;
    @(negedge clk);
    repeat (3) tick(took);
    reset = 1'b0;
    #1;
    check("rst_out_valid", 32'(io.out_valid), 32'd0);
    check("rst_sum",       32'(io.sum),       32'd0);
    check("rst_cout",      32'(io.cout),      32'd0);
    check("rst_ovf",       32'(io.ovf),       32'd0);
    check("rst_zero",      32'(io.zero),      32'd0);
    check("rst_in_ready",  32'(io.in_ready),  32'd1);
    @(negedge clk);
    cyc++;

    // Directed corner cases, each with its expected flags spelled out; latency checked too.
    lat_mode = 1'b1;
    send(8'h0F, 8'h01, 1'b0, 1'b1, '{sum: 8'h10, cout: 1'b0, ovf: 1'b0, zero: 1'b0});
    drain();
    send(8'hFF, 8'h01, 1'b0, 1'b1, '{sum: 8'h00, cout: 1'b1, ovf: 1'b0, zero: 1'b1});
    send(8'h7F, 8'h01, 1'b0, 1'b1, '{sum: 8'h80, cout: 1'b0, ovf: 1'b1, zero: 1'b0});
    send(8'h05, 8'h07, 1'b1, 1'b1, '{sum: 8'hFE, cout: 1'b0, ovf: 1'b0, zero: 1'b0});
    send(8'h80, 8'h01, 1'b1, 1'b1, '{sum: 8'h7F, cout: 1'b1, ovf: 1'b1, zero: 1'b0});
    drain();

    // Back-to-back: fixed latency on each beat implies four consecutive output cycles.
    for (int i = 1; i <= 4; i++) begin
      send(8'(i), 8'(i), 1'b0, 1'b1, '{sum: 8'(2 * i), cout: 1'b0, ovf: 1'b0, zero: 1'b0});
    end
    drain();
    lat_mode = 1'b0;

    // Mid-stream stall: fill the pipe, then hold out_ready low for five cycles.
    for (int i = 0; i < 5; i++) send(8'(16 + i), 8'(3 * i), 1'(i & 1), 1'b0, '0);
    io.in_valid  = 1'b1;
    io.a         = 8'h44;
    io.b         = 8'h55;
    io.sub       = 1'b1;
    io.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_out_valid", 32'(io.out_valid), 32'd1);
      check("stall_in_ready",  32'(io.in_ready),  32'd0);
      if (i == 0) begin
        held = '{sum: io.sum, cout: io.cout, ovf: io.ovf, zero: io.zero};
      end else begin
        check("stall_hold", 32'({io.sum, io.cout, io.ovf, io.zero}), 32'(held));
      end
      tick(took);
    end
    io.out_ready = 1'b1;
    took = 1'b0;
    for (int n = 0; n < 10 && !took; n++) tick(took);
    check("stall_resume_accept", 32'(took), 32'd1);
    drain();

    // Reset with two beats in flight: nothing from them may ever appear.
    send(8'h12, 8'h34, 1'b0, 1'b0, '0);
    send(8'h56, 8'h78, 1'b1, 1'b0, '0);
    reset = 1'b1;
    tick(took);
    reset = 1'b0;
    exp_q.delete();
    acc_q.delete();
    #1;
    check("rst_flush_vld", 32'(io.out_valid), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick(took);
      check("rst_no_stale", 32'(io.out_valid), 32'd0);
    end

    // Random traffic with random backpressure and bubbles.
    took = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      io.out_ready = ($urandom_range(0, 3) != 0);
      if (took || !io.in_valid) begin
        io.in_valid = ($urandom_range(0, 3) != 0);
        io.a        = pick();
        io.b        = pick();
        io.sub      = 1'($urandom_range(0, 1));
      end
      tick(took);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
